// File: rtl/cp0_exc_unit_pkg.sv
// cp0_exc_unit_pkg: CP0 register indices, field positions and ExcCode constants
package cp0_exc_unit_pkg;
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;
   localparam int SR_IE   = 0;
   localparam int SR_EXL  = 1;
   localparam int IM_LO   = 10;
   localparam int CA_BD   = 31;
   localparam int EXC_LO  = 2;
   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;
endpackage

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if: M-stage pipeline <-> CP0 signal bundle
interface cp0_exc_unit_if;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic [31:0] m_pc;
   logic        m_bd;
   logic [4:0]  m_exccode;
   logic        m_eret;
   logic [5:0]  hwint;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;
   modport master (
      output we, addr, din, m_pc, m_bd, m_exccode, m_eret, hwint,
      input  dout, req, handler_pc, epc_out
   );
   modport slave (
      input  we, addr, din, m_pc, m_bd, m_exccode, m_eret, hwint,
      output dout, req, handler_pc, epc_out
   );
endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 SR/Cause/EPC registers with M-stage exception/interrupt arbitration
module cp0_exc_unit
   import cp0_exc_unit_pkg::*;
#(
   parameter logic [31:0] PRID    = 32'h2023_0601,
   parameter logic [31:0] HANDLER = 32'h0000_4180
) (
   input logic           clk,
   input logic           reset,
   cp0_exc_unit_if.slave bus
);
   logic [5:0]  im_q, im_d, ip_q, ip_d;
   logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [4:0]  exc_q, exc_d;
   logic [31:0] epc_q, epc_d, sr_w, cause_w;
   logic        int_req, exc_req, req, wr_sr, wr_epc;

   assign int_req = ie_q & ~exl_q & |(bus.hwint & im_q);
   assign exc_req = ~exl_q & (bus.m_exccode != EXC_INT);
   assign req     = int_req | exc_req;
   assign wr_sr   = bus.we & ~req & (bus.addr == REG_SR);
   assign wr_epc  = bus.we & ~req & (bus.addr == REG_EPC);
   assign sr_w    = {16'h0, im_q, 8'h0, exl_q, ie_q};
   assign cause_w = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};

   assign bus.req        = req;
   assign bus.handler_pc = HANDLER;
   assign bus.epc_out    = epc_q;
   assign bus.dout       = bus.addr == REG_SR    ? sr_w    :
                           bus.addr == REG_CAUSE ? cause_w :
                           bus.addr == REG_EPC   ? epc_q   :
                           bus.addr == REG_PRID  ? PRID    : 32'h0;

   // SR next state: exception entry sets EXL; otherwise mtc0 then eret (eret clears EXL last)
   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      if (req) begin
         exl_d = 1'b1;
      end else begin
         if (wr_sr) begin
            im_d  = bus.din[IM_LO +: 6];
            exl_d = bus.din[SR_EXL];
            ie_d  = bus.din[SR_IE];
         end
         if (bus.m_eret) exl_d = 1'b0;
      end
   end

   // Cause next state: IP always samples hwint; BD/ExcCode latch on a taken request
   always_comb begin
      ip_d  = bus.hwint;
      bd_d  = req ? bus.m_bd : bd_q;
      exc_d = req ? (int_req ? EXC_INT : bus.m_exccode) : exc_q;
   end

   // EPC next state: restart PC on a taken request (branch of a delay slot), else mtc0
   always_comb begin
      epc_d = req    ? (bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc) :
              wr_epc ? bus.din : epc_q;
   end

   // SR register
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
      end
   end

   // Cause register
   always_ff @(posedge clk) begin
      if (reset) begin
         ip_q  <= '0;
         bd_q  <= 1'b0;
         exc_q <= '0;
      end else begin
         ip_q  <= ip_d;
         bd_q  <= bd_d;
         exc_q <= exc_d;
      end
   end

   // EPC register
   always_ff @(posedge clk) begin
      if (reset) epc_q <= '0;
      else       epc_q <= epc_d;
   end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed and randomized checks against a register-word reference model
module tb_cp0_exc_unit;
   import cp0_exc_unit_pkg::*;
   localparam logic [31:0] PRID_V    = 32'h2023_0601;
   localparam logic [31:0] HANDLER_V = 32'h0000_4180;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] m_sr, m_cause, m_epc;

   always #5 clk = ~clk;

   cp0_exc_unit_if bus();
   cp0_exc_unit #(.PRID(PRID_V), .HANDLER(HANDLER_V)) dut (.clk(clk), .reset(reset), .bus(bus));

   function automatic logic [31:0] rd(input logic [4:0] a);
      return a == 5'd12 ? m_sr : a == 5'd13 ? m_cause : a == 5'd14 ? m_epc : a == 5'd15 ? PRID_V : 32'h0;
   endfunction

   function automatic logic m_int();
      return m_sr[0] && !m_sr[1] && ((bus.hwint & m_sr[15:10]) != 6'h0);
   endfunction

   function automatic logic m_req();
      return m_int() || (!m_sr[1] && bus.m_exccode != 5'd0);
   endfunction

   task automatic idle();
      bus.we = 1'b0; bus.addr = 5'd0; bus.din = 32'h0; bus.m_pc = 32'h0; bus.m_bd = 1'b0;
      bus.m_exccode = 5'd0; bus.m_eret = 1'b0; bus.hwint = 6'h0;
   endtask

   task automatic tick();
      logic r, i;
      i = m_int();
      r = m_req();
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
         m_cause[15:10] = bus.hwint;
         if (r) begin
            m_sr[1] = 1'b1;
            m_cause[31] = bus.m_bd;
            m_cause[6:2] = i ? 5'd0 : bus.m_exccode;
            m_epc = bus.m_pc - (bus.m_bd ? 32'd4 : 32'd0);
         end else begin
            if (bus.we && bus.addr == 5'd12) m_sr = bus.din & 32'h0000_FC03;
            if (bus.we && bus.addr == 5'd14) m_epc = bus.din;
            if (bus.m_eret) m_sr[1] = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; idle(); tick(); tick(); reset = 1'b0; #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", bus.req); end
      checks++; if (bus.epc_out !== 32'h0) begin failures++; $display("FAIL reset_epc got=%0h exp=0", bus.epc_out); end
      checks++; if (bus.handler_pc !== HANDLER_V) begin failures++; $display("FAIL handler_pc got=%0h exp=%0h", bus.handler_pc, HANDLER_V); end
      for (int a = 12; a < 15; a++) begin
         bus.addr = 5'(a); #1;
         checks++; if (bus.dout !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%0h exp=0", a, bus.dout); end
      end
      bus.addr = 5'd15; #1;
      checks++; if (bus.dout !== PRID_V) begin failures++; $display("FAIL prid got=%0h exp=%0h", bus.dout, PRID_V); end
   endtask

   task automatic test_interrupt();
      idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0401; tick();
      idle(); bus.hwint = 6'b000001; bus.m_pc = 32'h2000; #1;
      checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL int_req got=%0h exp=1", bus.req); end
      tick(); #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL int_req_drop got=%0h exp=0", bus.req); end
      checks++; if (bus.epc_out !== 32'h2000) begin failures++; $display("FAIL int_epc got=%0h exp=2000", bus.epc_out); end
      bus.addr = 5'd13; #1;
      checks++; if (bus.dout[6:2] !== EXC_INT) begin failures++; $display("FAIL int_exccode got=%0h exp=0", bus.dout[6:2]); end
      bus.addr = 5'd12; #1;
      checks++; if (bus.dout !== 32'h0000_0403) begin failures++; $display("FAIL int_sr got=%0h exp=403", bus.dout); end
      idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0; tick();
   endtask

   task automatic test_exception_bd();
      idle(); bus.m_exccode = EXC_ADEL; bus.m_pc = 32'h3008; bus.m_bd = 1'b1; #1;
      checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL exc_req got=%0h exp=1", bus.req); end
      tick(); idle(); bus.addr = 5'd13; #1;
      checks++; if (bus.epc_out !== 32'h3004) begin failures++; $display("FAIL bd_epc got=%0h exp=3004", bus.epc_out); end
      checks++; if (bus.dout !== 32'h8000_0010) begin failures++; $display("FAIL bd_cause got=%0h exp=80000010", bus.dout); end
   endtask

   task automatic test_exl_mask_eret();
      idle(); bus.m_exccode = EXC_OV; bus.m_pc = 32'h5000; #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL exl_mask got=%0h exp=0", bus.req); end
      tick(); idle(); bus.addr = 5'd13; #1;
      checks++; if (bus.dout !== 32'h8000_0010) begin failures++; $display("FAIL exl_cause got=%0h exp=80000010", bus.dout); end
      idle(); bus.m_eret = 1'b1; #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL eret_req got=%0h exp=0", bus.req); end
      tick(); idle(); bus.addr = 5'd12; #1;
      checks++; if (bus.dout[1] !== 1'b0) begin failures++; $display("FAIL eret_exl got=%0h exp=0", bus.dout[1]); end
      idle(); bus.m_exccode = EXC_OV; bus.m_pc = 32'h5000; #1;
      checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL reraise got=%0h exp=1", bus.req); end
      tick(); idle(); bus.addr = 5'd13; #1;
      checks++; if (bus.dout !== 32'h0000_0030) begin failures++; $display("FAIL ov_cause got=%0h exp=30", bus.dout); end
      checks++; if (bus.epc_out !== 32'h5000) begin failures++; $display("FAIL ov_epc got=%0h exp=5000", bus.epc_out); end
      idle(); bus.m_eret = 1'b1; tick();
   endtask

   task automatic test_req_over_mtc0();
      idle(); bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h3100; bus.m_exccode = EXC_RI; bus.m_pc = 32'h6000; #1;
      checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL ri_req got=%0h exp=1", bus.req); end
      tick(); idle(); bus.addr = 5'd13; #1;
      checks++; if (bus.epc_out !== 32'h6000) begin failures++; $display("FAIL ri_epc got=%0h exp=6000", bus.epc_out); end
      checks++; if (bus.dout !== 32'h0000_0028) begin failures++; $display("FAIL ri_cause got=%0h exp=28", bus.dout); end
      idle(); bus.m_eret = 1'b1; tick();
   endtask

   task automatic test_cause_ro_ip();
      idle(); bus.we = 1'b1; bus.addr = 5'd13; bus.din = 32'hFFFF_FFFF; bus.hwint = 6'b101010; tick();
      bus.we = 1'b0; #1;
      checks++; if (bus.dout !== 32'h0000_A828) begin failures++; $display("FAIL cause_ro got=%0h exp=a828", bus.dout); end
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL ip_noreq got=%0h exp=0", bus.req); end
   endtask

   task automatic test_sr_eret_same();
      idle(); bus.m_exccode = EXC_SYSCALL; bus.m_pc = 32'h7000; tick();
      idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'hFFFF_FFFF; bus.m_eret = 1'b1; #1;
      checks++; if (bus.dout !== 32'h0000_0002) begin failures++; $display("FAIL mfc0_prewrite got=%0h exp=2", bus.dout); end
      tick(); idle(); bus.addr = 5'd12; #1;
      checks++; if (bus.dout !== 32'h0000_FC01) begin failures++; $display("FAIL sr_eret got=%0h exp=fc01", bus.dout); end
      idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0; tick();
   endtask

   task automatic test_wrap();
      idle(); bus.m_exccode = EXC_ADES; bus.m_pc = 32'h0; bus.m_bd = 1'b1; tick(); #1;
      checks++; if (bus.epc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL epc_wrap got=%0h exp=fffffffc", bus.epc_out); end
      idle(); bus.m_eret = 1'b1; tick();
   endtask

   task automatic test_reset_mid_handler();
      idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_FC01; tick();
      idle(); bus.hwint = 6'h3F; bus.m_pc = 32'h8000; tick();
      reset = 1'b1; tick(); reset = 1'b0; bus.addr = 5'd12; #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%0h exp=0", bus.req); end
      checks++; if (bus.dout !== 32'h0) begin failures++; $display("FAIL rst_mid_sr got=%0h exp=0", bus.dout); end
      checks++; if (bus.epc_out !== 32'h0) begin failures++; $display("FAIL rst_mid_epc got=%0h exp=0", bus.epc_out); end
      tick(); #1;
      checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL rst_hwint_ignored got=%0h exp=0", bus.req); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bus.we = ($urandom_range(0, 2) == 0);
         bus.addr = 5'($urandom_range(10, 16));
         bus.din = $urandom;
         bus.m_pc = $urandom;
         bus.m_bd = 1'($urandom);
         bus.m_exccode = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         bus.m_eret = ($urandom_range(0, 3) == 0);
         bus.hwint = 6'($urandom);
         reset = ($urandom_range(0, 80) == 0);
         #1;
         checks++; if (bus.req !== m_req()) begin failures++; $display("FAIL rnd_req n=%0d got=%0h exp=%0h", n, bus.req, m_req()); end
         checks++; if (bus.dout !== rd(bus.addr)) begin failures++; $display("FAIL rnd_dout n=%0d addr=%0d got=%0h exp=%0h", n, bus.addr, bus.dout, rd(bus.addr)); end
         checks++; if (bus.epc_out !== m_epc) begin failures++; $display("FAIL rnd_epc n=%0d got=%0h exp=%0h", n, bus.epc_out, m_epc); end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      m_sr = 0; m_cause = 0; m_epc = 0;
      @(negedge clk);
      test_reset();
      test_interrupt();
      test_exception_bd();
      test_exl_mask_eret();
      test_req_over_mtc0();
      test_cause_ro_ip();
      test_sr_eret_same();
      test_wrap();
      test_reset_mid_handler();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
